// File: rtl/mips_cpu_instr_memory_if.sv
// mips_cpu_instr_memory_if: load stream, status and fetch bus of the instruction memory
interface mips_cpu_instr_memory_if #(parameter int DEPTH_WORDS = 256);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic          clk_enable;
  logic          load_restart;
  logic          load_valid;
  logic          load_ready;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_done;
  logic          load_overflow;
  logic [AW:0]   word_count;
  logic [31:0]   instr_address;
  logic [31:0]   instr_readdata;
  logic          addr_fault;
  logic [31:0]   load_checksum;
  modport master (
    output clk_enable, load_restart, load_valid, load_data, load_last, instr_address,
    input  load_ready, load_done, load_overflow, word_count, instr_readdata, addr_fault, load_checksum
  );
  modport slave (
    input  clk_enable, load_restart, load_valid, load_data, load_last, instr_address,
    output load_ready, load_done, load_overflow, word_count, instr_readdata, addr_fault, load_checksum
  );
endinterface

// File: rtl/mips_cpu_instr_memory.sv
// mips_cpu_instr_memory: stream-loaded instruction RAM with byte-swapped combinational fetch; LOAD_CHECKSUM_EN adds a running sum of stored words
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 256
) (
  input logic                    clk,
  input logic                    reset,
  mips_cpu_instr_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
  state_t      r_state, w_state_nx;
  logic [AW:0] r_count;
  logic        r_ovf;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] w_off, w_word;
  logic        w_beat, w_full, w_wr, w_hit, w_restart;
  assign w_restart = bus.clk_enable & bus.load_restart;
  assign w_full    = r_count == (AW+1)'(DEPTH_WORDS);
  assign w_beat    = bus.clk_enable & bus.load_valid & bus.load_ready;
  assign w_wr      = w_beat & ~w_full & ~bus.load_restart;
  assign bus.load_ready    = r_state != READY;
  assign bus.load_done     = r_state == READY;
  assign bus.load_overflow = r_ovf;
  assign bus.word_count    = r_count;
  // next state: restart wins, a last beat (even a dropped one) finishes the image
  always_comb begin
    w_state_nx = r_state;
    if (w_restart) w_state_nx = EMPTY;
    else if (w_beat && bus.load_last) w_state_nx = READY;
    else if (w_beat && r_state == EMPTY) w_state_nx = LOADING;
  end
  // state, saturating word count and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_restart) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_wr) r_count <= r_count + 1'b1;
        if (w_beat && w_full) r_ovf <= 1'b1;
      end
    end
  end
  // image storage; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_count[AW-1:0]] <= bus.load_data;
  end
`ifdef LOAD_CHECKSUM_EN
  logic [31:0] r_sum;
  // wrapping sum of words actually written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sum <= '0;
    else if (w_restart) r_sum <= '0;
    else if (w_wr) r_sum <= r_sum + bus.load_data;
  end
  assign bus.load_checksum = r_sum;
`else
  assign bus.load_checksum = '0;
`endif
  // BASE_ADDR is word aligned, so the offset's low bits carry the alignment; the
  // explicit >= test stops addresses below the base from wrapping into the image
  assign w_off = bus.instr_address - BASE_ADDR;
  assign w_hit = r_state == READY && w_off[1:0] == 2'b00 && bus.instr_address >= BASE_ADDR &&
                 w_off[31:2] < 30'(r_count);
  assign w_word = r_mem[w_off[AW+1:2]];
  assign bus.instr_readdata = w_hit ? {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]} : '0;
  assign bus.addr_fault     = r_state == READY && !w_hit && bus.instr_address != '0;
endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// tb_mips_cpu_instr_memory: scoreboard bench for a 256-word and a 4-word instance
module tb_mips_cpu_instr_memory;
  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int F_RD = 0, F_FLT = 1, F_DONE = 2, F_OVF = 3, F_CNT = 4, F_RDY = 5, F_CKS = 6;
  typedef struct {
    int          d;
    int          f;
    logic [31:0] e;
    string       n;
  } exp_t;
  logic clk, reset;
  int checks = 0, errors = 0;
  exp_t q[$];
  mips_cpu_instr_memory_if #(.DEPTH_WORDS(256)) bus_b ();
  mips_cpu_instr_memory_if #(.DEPTH_WORDS(4))   bus_s ();
  mips_cpu_instr_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(256)) u_big   (.clk(clk), .reset(reset), .bus(bus_b.slave));
  mips_cpu_instr_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(4))   u_small (.clk(clk), .reset(reset), .bus(bus_s.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] cks(logic [31:0] v);
`ifdef LOAD_CHECKSUM_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction
  function automatic logic [31:0] val(int d, int f);
    logic [31:0] v[7];
    if (d == 0) v = '{bus_b.instr_readdata, 32'(bus_b.addr_fault), 32'(bus_b.load_done),
                      32'(bus_b.load_overflow), 32'(bus_b.word_count), 32'(bus_b.load_ready), bus_b.load_checksum};
    else        v = '{bus_s.instr_readdata, 32'(bus_s.addr_fault), 32'(bus_s.load_done),
                      32'(bus_s.load_overflow), 32'(bus_s.word_count), 32'(bus_s.load_ready), bus_s.load_checksum};
    return v[f];
  endfunction
  always @(negedge clk) begin
    exp_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (val(x.d, x.f) !== x.e) begin
        errors++;
        $display("FAIL %s dut%0d got %h want %h", x.n, x.d, val(x.d, x.f), x.e);
      end
    end
  end
  task automatic chk(int d, int f, logic [31:0] e, string n);
    q.push_back('{d, f, e, n});
  endtask
  task automatic flush();
    @(negedge clk);
    #1;
  endtask
  task automatic drive(int d, logic v, logic [31:0] dat, logic last, logic rs);
    if (d == 0) begin
      bus_b.load_valid = v; bus_b.load_data = dat; bus_b.load_last = last; bus_b.load_restart = rs;
    end else begin
      bus_s.load_valid = v; bus_s.load_data = dat; bus_s.load_last = last; bus_s.load_restart = rs;
    end
  endtask
  task automatic cycle(int d, logic v, logic [31:0] dat, logic last, logic rs);
    drive(d, v, dat, last, rs);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic beat(int d, logic [31:0] dat, logic last);
    cycle(d, 1'b1, dat, last, 1'b0);
  endtask
  task automatic status(int d, logic [31:0] cnt, logic done, logic ovf, string n);
    chk(d, F_CNT, cnt, {n, "_count"});
    chk(d, F_DONE, 32'(done), {n, "_done"});
    chk(d, F_RDY, 32'(!done), {n, "_ready"});
    chk(d, F_OVF, 32'(ovf), {n, "_ovf"});
    flush();
  endtask
  task automatic fetch(int d, logic [31:0] a, logic [31:0] rd, logic flt, string n);
    if (d == 0) bus_b.instr_address = a; else bus_s.instr_address = a;
    chk(d, F_RD, rd, {n, "_rd"});
    chk(d, F_FLT, 32'(flt), {n, "_fault"});
    flush();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b0;
    bus_b.clk_enable = 1'b1; bus_s.clk_enable = 1'b1;
    bus_b.instr_address = BASE; bus_s.instr_address = BASE;
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    status(0, 0, 1'b0, 1'b0, "reset");
    chk(0, F_CKS, 32'h0, "reset_cks");
    fetch(0, BASE, 32'h0, 1'b0, "reset_fetch");
    beat(0, 32'h24846006, 1'b0);
    beat(0, 32'h00A41006, 1'b0);
    status(0, 2, 1'b0, 1'b0, "load_mid");
    beat(0, 32'h00000008, 1'b0);
    beat(0, 32'h24000000, 1'b1);
    status(0, 4, 1'b1, 1'b0, "load_done");
    fetch(0, 32'hBFC00004, 32'h0610A400, 1'b0, "fetch_w1");
    fetch(0, 32'hBFC00000, 32'h06608424, 1'b0, "fetch_w0");
    fetch(0, 32'hBFC0000C, 32'h00000024, 1'b0, "fetch_w3");
    fetch(0, 32'hBFC00010, 32'h0, 1'b1, "fetch_past");
    fetch(0, 32'hBFC00002, 32'h0, 1'b1, "fetch_misalign");
    fetch(0, 32'h00000000, 32'h0, 1'b0, "fetch_halt");
    fetch(0, 32'hBFBFFFFC, 32'h0, 1'b1, "fetch_below");
    fetch(0, 32'hFFFFFFFC, 32'h0, 1'b1, "fetch_high");
    beat(0, 32'hDEADBEEF, 1'b0);
    status(0, 4, 1'b1, 1'b0, "ready_ignores");
    cycle(0, 1'b0, 32'h0, 1'b0, 1'b1);
    beat(0, 32'h11111111, 1'b0);
    beat(0, 32'h22222222, 1'b0);
    status(0, 2, 1'b0, 1'b0, "pre_reset");
    #2 reset = 1'b0;
    status(0, 0, 1'b0, 1'b0, "async_reset");
    fetch(0, BASE, 32'h0, 1'b0, "empty_fetch");
    reset = 1'b1;
    beat(0, 32'h0000000F, 1'b1);
    status(0, 1, 1'b1, 1'b0, "reload");
    fetch(0, 32'hBFC00000, 32'h0F000000, 1'b0, "reload_w0");
    fetch(0, 32'hBFC00004, 32'h0, 1'b1, "reload_w1");
    cycle(0, 1'b0, 32'h0, 1'b0, 1'b1);
    beat(0, 32'h11111111, 1'b0);
    cycle(0, 1'b1, 32'h22222222, 1'b1, 1'b1);
    status(0, 0, 1'b0, 1'b0, "restart_beat");
    beat(0, 32'h0A0B0C0D, 1'b0);
    bus_b.clk_enable = 1'b0;
    beat(0, 32'h33333333, 1'b0);
    cycle(0, 1'b1, 32'h44444444, 1'b1, 1'b1);
    status(0, 1, 1'b0, 1'b0, "frozen");
    bus_b.clk_enable = 1'b1;
    beat(0, 32'h12345678, 1'b1);
    status(0, 2, 1'b1, 1'b0, "thaw_load");
    chk(0, F_CKS, cks(32'h1C3F6285), "cks_restart");
    bus_b.clk_enable = 1'b0;
    fetch(0, 32'hBFC00000, 32'h0D0C0B0A, 1'b0, "frozen_w0");
    fetch(0, 32'hBFC00004, 32'h78563412, 1'b0, "frozen_w1");
    bus_b.clk_enable = 1'b1;
    cycle(0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk(0, F_CKS, 32'h0, "cks_cleared");
    beat(0, 32'hFFFFFFFF, 1'b0);
    beat(0, 32'h00000002, 1'b1);
    chk(0, F_CKS, cks(32'h00000001), "cks_wrap");
    status(0, 2, 1'b1, 1'b0, "cks_load");
    beat(1, 32'h01020304, 1'b0);
    beat(1, 32'h05060708, 1'b0);
    beat(1, 32'h090A0B0C, 1'b0);
    beat(1, 32'h0D0E0F10, 1'b0);
    status(1, 4, 1'b0, 1'b0, "small_full");
    beat(1, 32'hAAAAAAAA, 1'b0);
    status(1, 4, 1'b0, 1'b1, "small_drop");
    beat(1, 32'hBBBBBBBB, 1'b1);
    status(1, 4, 1'b1, 1'b1, "small_last");
    chk(1, F_CKS, cks(32'h1C202428), "small_cks");
    fetch(1, 32'hBFC0000C, 32'h100F0E0D, 1'b0, "small_w3");
    fetch(1, 32'hBFC00000, 32'h04030201, 1'b0, "small_w0");
    fetch(1, 32'hBFC00010, 32'h0, 1'b1, "small_past");
    cycle(1, 1'b0, 32'h0, 1'b0, 1'b1);
    status(1, 0, 1'b0, 1'b0, "small_restart");
    flush();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
